ram_host_arbiter: RTL and testbench

- Multi-host front end that sits directly upstream of the 32-bit single-port RAM.
- Arbitrates N host request ports (Ibex-style req/gnt/rvalid protocol) onto the RAM's single request port.
- Range-checks each access against the RAM window and routes the RAM's one-cycle response back to the host that issued it.
- Out-of-window accesses never reach the RAM; they are answered locally with an error response.

---
 rtl/ram_host_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram_host_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_host_arbiter.sv
// Round-robin front end for the single-port RAM. Out-of-window accesses are
// answered locally with an error. In-window responses are routed back to the issuing host.
module ram_host_arbiter #(
  parameter int unsigned NumHosts = 2,
  parameter logic [31:0] MemBase  = 32'h0010_0000,
  parameter logic [31:0] MemSize  = 32'h0000_0200
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumHosts-1:0]      host_req_i,
  input  logic [NumHosts-1:0]      host_we_i,
  input  logic [NumHosts*4-1:0]    host_be_i,
  input  logic [NumHosts*32-1:0]   host_addr_i,
  input  logic [NumHosts*32-1:0]   host_wdata_i,
  output logic [NumHosts-1:0]      host_gnt_o,
  output logic [NumHosts-1:0]      host_rvalid_o,
  output logic [NumHosts-1:0]      host_err_o,
  output logic [31:0]              host_rdata_o,
  output logic                     ram_req_o,
  output logic                     ram_we_o,
  output logic [3:0]               ram_be_o,
  output logic [31:0]              ram_addr_o,
  output logic [31:0]              ram_wdata_o,
  input  logic                     ram_rvalid_i,
  input  logic [31:0]              ram_rdata_i
);

  localparam int unsigned IdxW = $clog2(NumHosts);
  typedef logic [IdxW-1:0] idx_t;

  logic [3:0]  be_arr    [NumHosts];
  logic [31:0] addr_arr  [NumHosts];
  logic [31:0] wdata_arr [NumHosts];

  for (genvar i = 0; i < NumHosts; i++) begin : g_unpack
    assign be_arr[i]    = host_be_i[4*i +: 4];
    assign addr_arr[i]  = host_addr_i[32*i +: 32];
    assign wdata_arr[i] = host_wdata_i[32*i +: 32];
  end

  idx_t        last_q;
  logic        gnt_any;
  idx_t        gnt_idx;
  idx_t        cand_idx;
  int unsigned cand;

  // Search starts one past the last winner and wraps, so every requester is
  // served within NumHosts grants.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NumHosts; k++) begin
      cand     = (32'(last_q) + k) % NumHosts;
      cand_idx = idx_t'(cand);
      if (!gnt_any && host_req_i[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  logic [31:0] sel_addr;
  logic [32:0] off33;
  logic        in_range;

  // Widened to 33 bits so a window ending at 32'hFFFF_FFFF cannot wrap.
  assign sel_addr = addr_arr[gnt_idx];
  assign off33    = {1'b0, sel_addr} - {1'b0, MemBase};
  assign in_range = ({1'b0, sel_addr} >= {1'b0, MemBase}) && (off33 < {1'b0, MemSize});

  always_comb begin
    host_gnt_o  = '0;
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (gnt_any) begin
      host_gnt_o[gnt_idx] = 1'b1;
      if (in_range) begin
        ram_req_o   = 1'b1;
        ram_we_o    = host_we_i[gnt_idx];
        ram_be_o    = be_arr[gnt_idx];
        ram_addr_o  = off33[31:0];
        ram_wdata_o = wdata_arr[gnt_idx];
      end
    end
  end

  logic rsp_valid_q;
  idx_t rsp_host_q;
  logic rsp_err_q;
  logic rsp_we_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst_i) begin
      last_q      <= idx_t'(NumHosts - 1);
      rsp_valid_q <= 1'b0;
      rsp_host_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      rsp_valid_q <= gnt_any;
      if (gnt_any) begin
        last_q     <= gnt_idx;
        rsp_host_q <= gnt_idx;
        rsp_err_q  <= !in_range;
        rsp_we_q   <= host_we_i[gnt_idx];
      end
    end
  end

  // A RAM ack is forwarded only when an in-window access is outstanding.
  // A stray ack is dropped.
  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    if (rsp_valid_q && rsp_err_q) begin
      host_rvalid_o[rsp_host_q] = 1'b1;
      host_err_o[rsp_host_q]    = 1'b1;
    end else if (rsp_valid_q && ram_rvalid_i) begin
      host_rvalid_o[rsp_host_q] = 1'b1;
      if (!rsp_we_q) host_rdata_o = ram_rdata_i;
    end
  end

  a_ram_ack: assert property (@(posedge clk_i) disable iff (rst_i)
    ram_rvalid_i == (rsp_valid_q && !rsp_err_q));

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(host_gnt_o));

endmodule

// File: tb/tb_ram_host_arbiter.sv
// Randomized and directed bench for ram_host_arbiter against a transaction-level model.
// A second instance covers a RAM window that ends at the top of the address space.
module tb_ram_host_arbiter;

  localparam int NH = 3;
  localparam logic [31:0] MEM_BASE = 32'h0010_0000;
  localparam logic [31:0] MEM_SIZE = 32'h0000_0200;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [NH-1:0]    host_req = '0, host_we = '0;
  logic [NH*4-1:0]  host_be = '0;
  logic [NH*32-1:0] host_addr = '0, host_wdata = '0;
  logic [NH-1:0]    host_gnt, host_rvalid, host_err;
  logic [31:0]      host_rdata;
  logic             ram_req, ram_we, ram_rvalid;
  logic [3:0]       ram_be;
  logic [31:0]      ram_addr, ram_wdata, ram_rdata;

  ram_host_arbiter #(.NumHosts(NH), .MemBase(MEM_BASE), .MemSize(MEM_SIZE)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_err_o(host_err),
    .host_rdata_o(host_rdata),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata)
  );

  // RAM environment: one-cycle latency, junk on rdata whenever no read returns.
  logic [31:0] ram_mem [128];
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ram_rvalid <= 1'b0;
      ram_rdata  <= 32'h0;
    end else begin
      ram_rvalid <= ram_req;
      ram_rdata  <= $urandom;
      if (ram_req) begin
        if (ram_we) begin
          for (int b = 0; b < 4; b++)
            if (ram_be[b]) ram_mem[ram_addr[8:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end else begin
          ram_rdata <= ram_mem[ram_addr[8:2]];
        end
      end
    end
  end

  // Wrap-window instance.
  logic [1:0]  w_req = '0, w_we = '0;
  logic [7:0]  w_be = '0;
  logic [63:0] w_addr = '0, w_wdata = '0;
  logic [1:0]  w_gnt, w_rvalid, w_err;
  logic [31:0] w_rdata;
  logic        w_ram_req, w_ram_we, w_ram_rvalid;
  logic [3:0]  w_ram_be;
  logic [31:0] w_ram_addr, w_ram_wdata, w_ram_rdata;

  ram_host_arbiter #(.NumHosts(2), .MemBase(32'hFFFF_FE00), .MemSize(32'h0000_0200)) u_wrap (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_req_i(w_req), .host_we_i(w_we), .host_be_i(w_be),
    .host_addr_i(w_addr), .host_wdata_i(w_wdata),
    .host_gnt_o(w_gnt), .host_rvalid_o(w_rvalid), .host_err_o(w_err),
    .host_rdata_o(w_rdata),
    .ram_req_o(w_ram_req), .ram_we_o(w_ram_we), .ram_be_o(w_ram_be),
    .ram_addr_o(w_ram_addr), .ram_wdata_o(w_ram_wdata),
    .ram_rvalid_i(w_ram_rvalid), .ram_rdata_i(w_ram_rdata)
  );

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_ram_rvalid <= 1'b0;
      w_ram_rdata  <= 32'h0;
    end else begin
      w_ram_rvalid <= w_ram_req;
      w_ram_rdata  <= ~w_ram_addr;
    end
  end

  // Reference model: memory image, round-robin pointer, one pending response.
  logic [31:0] ref_mem [128];
  int          last;
  bit          pend_valid, pend_err;
  int          pend_host;
  logic [31:0] pend_data;

  int vectors = 0;
  int miscompares = 0;

  task automatic reset_model();
    last       = NH - 1;
    pend_valid = 1'b0;
    pend_err   = 1'b0;
    pend_host  = 0;
    pend_data  = '0;
  endtask

  task automatic set_host(input int h, input bit req, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    host_req[h]            = req;
    host_we[h]             = we;
    host_be[4*h +: 4]      = be;
    host_addr[32*h +: 32]  = addr;
    host_wdata[32*h +: 32] = wdata;
  endtask

  task automatic clear_hosts();
    host_req = '0; host_we = '0; host_be = '0; host_addr = '0; host_wdata = '0;
  endtask

  // Called at a negedge with inputs already driven; compares this cycle's
  // outputs, advances one clock and ends on the next negedge.
  task automatic step(input string tag, output int win);
    logic [NH-1:0] exp_gnt, exp_rv, exp_err;
    logic [31:0]   exp_rdata, a;
    longint unsigned la;
    bit            inr, exp_ram_req;
    int            wi;
    #1;
    win = -1;
    for (int k = 1; k <= NH; k++) begin
      int h;
      h = (last + k) % NH;
      if (win < 0 && host_req[h]) win = h;
    end
    exp_gnt = '0;
    inr = 1'b0;
    a = '0;
    if (win >= 0) begin
      exp_gnt[win] = 1'b1;
      a   = host_addr[32*win +: 32];
      la  = longint'(a);
      inr = (la >= longint'(MEM_BASE)) && (la - longint'(MEM_BASE) < longint'(MEM_SIZE));
    end
    exp_ram_req = (win >= 0) && inr;

    vectors++;
    if (host_gnt !== exp_gnt) begin
      miscompares++;
      $display("FAIL %s gnt: got %b want %b", tag, host_gnt, exp_gnt);
    end
    vectors++;
    if (ram_req !== exp_ram_req) begin
      miscompares++;
      $display("FAIL %s ram_req: got %b want %b", tag, ram_req, exp_ram_req);
    end
    if (exp_ram_req) begin
      vectors++;
      if (ram_addr !== a - MEM_BASE || ram_we !== host_we[win] ||
          ram_be !== host_be[4*win +: 4] || ram_wdata !== host_wdata[32*win +: 32]) begin
        miscompares++;
        $display("FAIL %s ram_cmd: got a=%h we=%b be=%b d=%h want a=%h we=%b be=%b d=%h",
                 tag, ram_addr, ram_we, ram_be, ram_wdata, a - MEM_BASE, host_we[win],
                 host_be[4*win +: 4], host_wdata[32*win +: 32]);
      end
    end

    exp_rv = '0; exp_err = '0; exp_rdata = '0;
    if (pend_valid) begin
      exp_rv[pend_host]  = 1'b1;
      exp_err[pend_host] = pend_err;
      exp_rdata          = pend_data;
    end
    vectors++;
    if (host_rvalid !== exp_rv || host_err !== exp_err || host_rdata !== exp_rdata) begin
      miscompares++;
      $display("FAIL %s rsp: got rv=%b err=%b rd=%h want rv=%b err=%b rd=%h",
               tag, host_rvalid, host_err, host_rdata, exp_rv, exp_err, exp_rdata);
    end

    @(posedge clk_i);
    pend_valid = (win >= 0);
    if (win >= 0) begin
      last      = win;
      pend_host = win;
      pend_err  = !inr;
      pend_data = '0;
      if (inr) begin
        wi = int'((a - MEM_BASE) >> 2);
        if (host_we[win]) begin
          for (int b = 0; b < 4; b++)
            if (host_be[4*win + b]) ref_mem[wi][8*b +: 8] = host_wdata[32*win + 8*b +: 8];
        end else begin
          pend_data = ref_mem[wi];
        end
      end
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    clear_hosts();
    reset_model();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    #1;
    vectors++;
    if (host_rvalid !== '0 || host_err !== '0 || host_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rv=%b err=%b rd=%h want 0", host_rvalid, host_err, host_rdata);
    end
    vectors++;
    if (ram_req !== 1'b0 || host_gnt !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: got ram_req=%b gnt=%b want 0", ram_req, host_gnt);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    int w;
    set_host(0, 1, 0, 4'hF, 32'h0010_0004, 0);
    #1;
    vectors++;
    if (ram_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL single_addr: got %h want 00000004", ram_addr);
    end
    step("single_req", w);
    clear_hosts();
    #1;
    vectors++;
    if (host_rvalid[0] !== 1'b1 || host_err[0] !== 1'b0 || host_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL single_rsp: got rv=%b err=%b rd=%h want 1 0 deadbeef",
               host_rvalid[0], host_err[0], host_rdata);
    end
    step("single_rsp", w);
  endtask

  task automatic test_round_robin();
    int w;
    int order [4] = '{0, 1, 0, 1};
    do_reset();
    set_host(0, 1, 0, 4'hF, 32'h0010_0010, 0);
    set_host(1, 1, 0, 4'hF, 32'h0010_0014, 0);
    for (int i = 0; i < 4; i++) begin
      step("rr", w);
      vectors++;
      if (w != order[i]) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", i, w, order[i]);
      end
    end
    clear_hosts();
    step("rr_drain", w);
  endtask

  task automatic test_write_read();
    int w;
    set_host(1, 1, 1, 4'b0011, 32'h0010_0008, 32'h1234_5678);
    step("wr", w);
    set_host(1, 1, 0, 4'hF, 32'h0010_0008, 0);
    step("wr_then_rd", w);
    clear_hosts();
    #1;
    vectors++;
    if (host_rvalid[1] !== 1'b1 || host_rdata !== 32'hFFFF_5678) begin
      miscompares++;
      $display("FAIL wr_readback: got rv=%b rd=%h want 1 ffff5678", host_rvalid[1], host_rdata);
    end
    step("wr_drain", w);
  endtask

  task automatic test_out_of_range();
    int w;
    set_host(0, 1, 0, 4'hF, 32'h0010_0200, 0);
    step("oor_hi", w);
    set_host(0, 1, 0, 4'hF, 32'h000F_FFFC, 0);
    step("oor_lo", w);
    clear_hosts();
    #1;
    vectors++;
    if (host_rvalid[0] !== 1'b1 || host_err[0] !== 1'b1 || host_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL oor_rsp: got rv=%b err=%b rd=%h want 1 1 0", host_rvalid[0], host_err[0], host_rdata);
    end
    step("oor_drain", w);
  endtask

  task automatic test_wrap();
    @(negedge clk_i);
    w_req = 2'b01; w_we = '0; w_be = 8'h0F; w_addr = {32'h0, 32'hFFFF_FFFC};
    #1;
    vectors++;
    if (w_gnt !== 2'b01 || w_ram_req !== 1'b1 || w_ram_addr !== 32'h1FC) begin
      miscompares++;
      $display("FAIL wrap_top: got gnt=%b req=%b a=%h want 01 1 000001fc", w_gnt, w_ram_req, w_ram_addr);
    end
    @(negedge clk_i);
    w_addr = {32'h0, 32'h0000_0000};
    #1;
    vectors++;
    if (w_rvalid !== 2'b01 || w_err !== 2'b00 || w_rdata !== ~32'h1FC) begin
      miscompares++;
      $display("FAIL wrap_top_rsp: got rv=%b err=%b rd=%h want 01 00 %h", w_rvalid, w_err, w_rdata, ~32'h1FC);
    end
    vectors++;
    if (w_gnt !== 2'b01 || w_ram_req !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_zero: got gnt=%b req=%b want 01 0", w_gnt, w_ram_req);
    end
    @(negedge clk_i);
    w_req = '0;
    #1;
    vectors++;
    if (w_rvalid !== 2'b01 || w_err !== 2'b01 || w_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_zero_rsp: got rv=%b err=%b rd=%h want 01 01 0", w_rvalid, w_err, w_rdata);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_midop();
    int w;
    do_reset();
    set_host(1, 1, 0, 4'hF, 32'h0010_0004, 0);
    step("midop_gnt1", w);
    clear_hosts();
    rst_i = 1'b1;
    #1;
    vectors++;
    if (host_rvalid !== '0 || host_err !== '0) begin
      miscompares++;
      $display("FAIL midop_in_reset: got rv=%b err=%b want 0", host_rvalid, host_err);
    end
    reset_model();
    @(negedge clk_i);
    rst_i = 1'b0;
    step("midop_after", w);
    set_host(0, 1, 0, 4'hF, 32'h0010_0000, 0);
    set_host(1, 1, 0, 4'hF, 32'h0010_0004, 0);
    step("midop_first", w);
    vectors++;
    if (w != 0) begin
      miscompares++;
      $display("FAIL midop_priority: got host %0d want 0", w);
    end
    clear_hosts();
    step("midop_drain", w);
  endtask

  task automatic test_back_to_back_random();
    int w;
    logic [31:0] a;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int h = 0; h < NH; h++) begin
        if (!host_req[h] && ($urandom_range(0, 3) != 0)) begin
          case ($urandom_range(0, 5))
            0:       a = MEM_BASE + MEM_SIZE + ($urandom_range(0, 15) << 2);
            1:       a = MEM_BASE - ($urandom_range(1, 8) << 2);
            2:       a = $urandom;
            default: a = MEM_BASE + ($urandom_range(0, 127) << 2);
          endcase
          set_host(h, 1, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
        end
      end
      step("rand", w);
      if (w >= 0) set_host(w, 0, 0, 4'h0, 32'h0, 32'h0);
    end
    clear_hosts();
    step("rand_drain", w);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      ram_mem[i] = 32'h0100_0000 * i + 32'h55;
      ref_mem[i] = 32'h0100_0000 * i + 32'h55;
    end
    ram_mem[1] = 32'hDEAD_BEEF; ref_mem[1] = 32'hDEAD_BEEF;
    ram_mem[2] = 32'hFFFF_FFFF; ref_mem[2] = 32'hFFFF_FFFF;
    reset_model();

    test_reset();
    test_single();
    test_round_robin();
    test_write_read();
    test_out_of_range();
    test_wrap();
    test_reset_midop();
    test_back_to_back_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
